// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame receiver: start bit, WIDTH data bits MSB first,
// optional even parity, stop bit (0). Delivers words through a valid/ready holding register.
module sipo_frame_ctrl #(
   parameter int WIDTH     = 4,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             pready,
   input  logic             clr_ovr,
   output logic [WIDTH-1:0] pout,
   output logic             pvalid,
   output logic             busy,
   output logic             perr,
   output logic             ferr,
   output logic             ovr
);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_shift;
   logic             r_par;
   logic [WIDTH-1:0] r_pout;
   logic             r_pvalid;
   logic             r_busy;
   logic             r_perr;
   logic             r_ferr;
   logic             r_ovr;

   logic w_par_bad;
   logic w_load_ok;

   // Even parity: data XOR parity bit must be zero.
   assign w_par_bad = PARITY_EN ? ((^r_shift) ^ r_par) : 1'b0;
   assign w_load_ok = !r_pvalid || pready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_shift  <= '0;
         r_par    <= 1'b0;
         r_pout   <= '0;
         r_pvalid <= 1'b0;
         r_busy   <= 1'b0;
         r_perr   <= 1'b0;
         r_ferr   <= 1'b0;
         r_ovr    <= 1'b0;
      end else begin
         // NOTE: defaults come first; a later non-blocking assignment to the same
         // register in this block overrides them, which gives overrun-set priority
         // over clr_ovr and a fresh load priority over the consume-clear of pvalid.
         r_perr <= 1'b0;
         r_ferr <= 1'b0;
         if (clr_ovr) r_ovr <= 1'b0;
         if (r_pvalid && pready) r_pvalid <= 1'b0;

         case (r_state)
            IDLE: begin
               if (din) begin
                  r_state <= DATA;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            DATA: begin
               r_shift <= {r_shift[WIDTH-2:0], din};
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == LAST) r_state <= PARITY_EN ? PARITY : STOP;
            end
            PARITY: begin
               r_par   <= din;
               r_state <= STOP;
            end
            STOP: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               // Stop-bit error masks parity error; bad frames never touch pout.
               if (din) begin
                  r_ferr <= 1'b1;
               end else if (w_par_bad) begin
                  r_perr <= 1'b1;
               end else if (w_load_ok) begin
                  r_pout   <= r_shift;
                  r_pvalid <= 1'b1;
               end else begin
                  r_ovr <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign pout   = r_pout;
   assign pvalid = r_pvalid;
   assign busy   = r_busy;
   assign perr   = r_perr;
   assign ferr   = r_ferr;
   assign ovr    = r_ovr;

endmodule
